// File: rtl/i_tree_pkg.sv
// i_tree_pkg: shared types and default constants for the i_tree scan scheduler.
//   sched_state_t : scheduler FSM states
//   I_TREE_*      : default channel count and dwell timing
package i_tree_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    SAMPLE  = 2'd2,
    ADVANCE = 2'd3
  } sched_state_t;

  localparam int unsigned I_TREE_SETTLE = 8;
  localparam int unsigned I_TREE_WINDOW = 32;
  localparam int unsigned I_TREE_NUM_CH = 4;

endpackage

// File: rtl/i_tree_rr_pick.sv
// i_tree_rr_pick: combinational round-robin channel picker.
//   mask       : candidate channels (1 = eligible)
//   start      : index the search is relative to
//   inclusive  : 1 = start itself is a candidate, 0 = search begins at start+1
//   next_idx   : first eligible index found (0 when none_valid)
//   wrapped    : search passed the top index and wrapped to the bottom
//   none_valid : mask is all zero
module i_tree_rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IW-1:0]     start,
  input  logic              inclusive,
  output logic [IW-1:0]     next_idx,
  output logic              wrapped,
  output logic              none_valid
);

  int unsigned off;
  int unsigned sum;
  int unsigned idx;
  logic        wr;

  // Offsets 0..NUM_CH-1 (inclusive) or 1..NUM_CH (exclusive); the exclusive
  // case at offset NUM_CH lands back on start, which counts as a wrap.
  always_comb begin
    next_idx   = '0;
    wrapped    = 1'b0;
    none_valid = 1'b1;
    off        = 0;
    sum        = 0;
    idx        = 0;
    wr         = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      off = k + (inclusive ? 0 : 1);
      sum = 32'(start) + off;
      if (sum >= NUM_CH) begin
        idx = sum - NUM_CH;
        wr  = 1'b1;
      end else begin
        idx = sum;
        wr  = 1'b0;
      end
      if (none_valid && mask[IW'(idx)]) begin
        none_valid = 1'b0;
        next_idx   = IW'(idx);
        wrapped    = wr;
      end
    end
  end

endmodule

// File: rtl/i_tree_scan_scheduler.sv
// i_tree_scan_scheduler: time-multiplexes one i_tree detector over NUM_CH
// sensor channels. Each enabled channel gets a dwell of SETTLE flush cycles
// (detector running, output ignored) then WINDOW sample cycles, followed by
// one ADVANCE cycle with the detector held in reset.
//   clk, rst_n      : clock, async active-low reset
//   run             : scanning enable (sampled in IDLE and ADVANCE)
//   ch_enable       : per-channel scan mask
//   sensor_in       : raw sensor bits
//   flag_clr        : write-1-to-clear for anomaly_flags
//   det_rst_n       : detector reset (low outside FLUSH/SAMPLE)
//   det_sensor_data : routed sensor bit, one register of latency
//   det_anomaly     : detector anomaly output
//   active_ch       : channel owning the detector
//   anomaly_flags   : sticky per-channel flags (set wins over clear)
//   scan_done       : 1-cycle pulse when the round-robin wraps
//   irq             : registered OR of anomaly_flags
module i_tree_scan_scheduler
  import i_tree_pkg::*;
#(
  parameter int unsigned NUM_CH = I_TREE_NUM_CH,
  parameter int unsigned SETTLE = I_TREE_SETTLE,
  parameter int unsigned WINDOW = I_TREE_WINDOW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         sensor_in,
  input  logic [NUM_CH-1:0]         flag_clr,
  output logic                      det_rst_n,
  output logic                      det_sensor_data,
  input  logic                      det_anomaly,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic [NUM_CH-1:0]         anomaly_flags,
  output logic                      scan_done,
  output logic                      irq
);

  localparam int unsigned IW      = $clog2(NUM_CH);
  localparam int unsigned CNT_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  sched_state_t      state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IW-1:0]     act_n;
  logic [NUM_CH-1:0] set_vec;
  logic [IW-1:0]     pick_idx;
  logic              pick_wrapped;
  logic              pick_none;
  logic              dwell_n;
  logic              adv_wrap;

  // One picker serves both IDLE (inclusive search) and ADVANCE (exclusive).
  i_tree_rr_pick #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_pick (
    .mask       (ch_enable),
    .start      (active_ch),
    .inclusive  (state == IDLE),
    .next_idx   (pick_idx),
    .wrapped    (pick_wrapped),
    .none_valid (pick_none)
  );

  always_comb begin
    state_n = state;
    act_n   = active_ch;
    cnt_n   = cnt;
    set_vec = '0;
    unique case (state)
      IDLE: begin
        if (run && !pick_none) begin
          act_n   = pick_idx;
          state_n = FLUSH;
          cnt_n   = '0;
        end
      end
      FLUSH: begin
        if (!ch_enable[active_ch]) begin
          state_n = ADVANCE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(SETTLE - 1)) begin
          state_n = SAMPLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (!ch_enable[active_ch]) begin
          state_n = ADVANCE;
          cnt_n   = '0;
        end else begin
          set_vec[active_ch] = det_anomaly;
          if (cnt == CNT_W'(WINDOW - 1)) begin
            state_n = ADVANCE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      ADVANCE: begin
        if (!run || pick_none) begin
          state_n = IDLE;
        end else begin
          act_n   = pick_idx;
          state_n = FLUSH;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Detector controls are registered from the next state so they line up
  // with the state they belong to; sensor data thus lags sensor_in by one.
  assign dwell_n  = (state_n == FLUSH) || (state_n == SAMPLE);
  assign adv_wrap = (state == ADVANCE) && !pick_none && pick_wrapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      active_ch       <= '0;
      cnt             <= '0;
      det_rst_n       <= 1'b0;
      det_sensor_data <= 1'b0;
      anomaly_flags   <= '0;
      scan_done       <= 1'b0;
      irq             <= 1'b0;
    end else begin
      state           <= state_n;
      active_ch       <= act_n;
      cnt             <= cnt_n;
      det_rst_n       <= dwell_n;
      det_sensor_data <= dwell_n & sensor_in[act_n];
      anomaly_flags   <= (anomaly_flags & ~flag_clr) | set_vec;
      scan_done       <= adv_wrap;
      irq             <= |anomaly_flags;
    end
  end

endmodule

// File: tb/tb_i_tree_scan_scheduler.sv
// tb_i_tree_scan_scheduler: directed bench for i_tree_scan_scheduler with
// NUM_CH=4, SETTLE=8, WINDOW=32 (41-cycle dwell period). Cycle n counts
// rising edges after reset release; outputs are observed at the falling edge
// following edge n, and inputs changed there are seen by edge n+1.
module tb_i_tree_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] ch_enable;
  logic [3:0] sensor_in;
  logic [3:0] flag_clr;
  logic       det_rst_n;
  logic       det_sensor_data;
  logic       det_anomaly;
  logic [1:0] active_ch;
  logic [3:0] anomaly_flags;
  logic       scan_done;
  logic       irq;

  int checks = 0;
  int errors = 0;
  int sd_cnt;
  int rl_cnt;

  always #5 clk = ~clk;

  i_tree_scan_scheduler #(
    .NUM_CH (4),
    .SETTLE (8),
    .WINDOW (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .ch_enable       (ch_enable),
    .sensor_in       (sensor_in),
    .flag_clr        (flag_clr),
    .det_rst_n       (det_rst_n),
    .det_sensor_data (det_sensor_data),
    .det_anomaly     (det_anomaly),
    .active_ch       (active_ch),
    .anomaly_flags   (anomaly_flags),
    .scan_done       (scan_done),
    .irq             (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_act"},   32'(active_ch),       32'd0);
    check({tag, "_drst"},  32'(det_rst_n),       32'd0);
    check({tag, "_dsd"},   32'(det_sensor_data), 32'd0);
    check({tag, "_flags"}, 32'(anomaly_flags),   32'd0);
    check({tag, "_sd"},    32'(scan_done),       32'd0);
    check({tag, "_irq"},   32'(irq),             32'd0);
  endtask

  // Leaves rst_n released at a falling edge with all inputs idle.
  task automatic do_reset();
    rst_n       = 1'b0;
    run         = 1'b0;
    ch_enable   = '0;
    sensor_in   = '0;
    flag_clr    = '0;
    det_anomaly = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst0");

    // Full rotation over all four channels.
    do_reset();
    run = 1'b1;
    ch_enable = 4'b1111;
    sd_cnt = 0;
    rl_cnt = 0;
    for (int n = 1; n <= 165; n++) begin
      @(negedge clk);
      if (scan_done) sd_cnt++;
      if (!det_rst_n) rl_cnt++;
      if (n == 1)   check("rr_act1",   32'(active_ch), 32'd0);
      if (n == 41)  check("rr_act41",  32'(active_ch), 32'd0);
      if (n == 41)  check("rr_drst41", 32'(det_rst_n), 32'd0);
      if (n == 40)  check("rr_drst40", 32'(det_rst_n), 32'd1);
      if (n == 42)  check("rr_act42",  32'(active_ch), 32'd1);
      if (n == 83)  check("rr_act83",  32'(active_ch), 32'd2);
      if (n == 124) check("rr_act124", 32'(active_ch), 32'd3);
      if (n == 165) check("rr_act165", 32'(active_ch), 32'd0);
      if (n == 165) check("rr_sd165",  32'(scan_done), 32'd1);
      if (n == 5)   check("rr_dsd5",   32'(det_sensor_data), 32'd0);
      if (n == 6)   check("rr_dsd6",   32'(det_sensor_data), 32'd1);
      if (n == 41)  check("rr_dsd41",  32'(det_sensor_data), 32'd0);
      if (n == 42)  check("rr_dsd42",  32'(det_sensor_data), 32'd0);
      if (n == 165) check("rr_dsd165", 32'(det_sensor_data), 32'd1);
      if (n == 5) sensor_in = 4'b0001;
    end
    check("rr_sd_count",   32'(sd_cnt), 32'd1);
    check("rr_rstlow_cnt", 32'(rl_cnt), 32'd4);
    check("rr_flags",      32'(anomaly_flags), 32'd0);

    // Channels 0 and 2: anomaly in ch2 FLUSH is ignored, in ch0 SAMPLE cnt 5 latches.
    do_reset();
    run = 1'b1;
    ch_enable = 4'b0101;
    for (int n = 1; n <= 98; n++) begin
      @(negedge clk);
      if (n == 42) check("m_act42",   32'(active_ch), 32'd2);
      if (n == 81) check("m_flags81", 32'(anomaly_flags), 32'd0);
      if (n == 91) check("m_act91",   32'(active_ch), 32'd0);
      if (n == 96) check("m_flags96", 32'(anomaly_flags), 32'd0);
      if (n == 97) check("m_flags97", 32'(anomaly_flags), 32'd1);
      if (n == 97) check("m_irq97",   32'(irq), 32'd0);
      if (n == 98) check("m_irq98",   32'(irq), 32'd1);
      det_anomaly = (n == 45) || (n == 96);
    end

    // Single channel 1: set/clear collision, then rescan every period.
    do_reset();
    run = 1'b1;
    ch_enable = 4'b0010;
    sd_cnt = 0;
    for (int n = 1; n <= 83; n++) begin
      @(negedge clk);
      if (scan_done) sd_cnt++;
      if (n == 1)  check("s_act1",    32'(active_ch), 32'd1);
      if (n == 13) check("s_flags13", 32'(anomaly_flags), 32'd2);
      if (n == 14) check("s_flags14", 32'(anomaly_flags), 32'd0);
      if (n == 14) check("s_irq14",   32'(irq), 32'd1);
      if (n == 15) check("s_irq15",   32'(irq), 32'd0);
      if (n == 41) check("s_drst41",  32'(det_rst_n), 32'd0);
      if (n == 42) check("s_act42",   32'(active_ch), 32'd1);
      if (n == 42) check("s_sd42",    32'(scan_done), 32'd1);
      if (n == 83) check("s_sd83",    32'(scan_done), 32'd1);
      det_anomaly = (n == 12);
      flag_clr    = ((n == 12) || (n == 13)) ? 4'b0010 : 4'b0000;
    end
    check("s_sd_count", 32'(sd_cnt), 32'd2);

    // Enable for ch1 dropped during its SAMPLE window.
    do_reset();
    run = 1'b1;
    ch_enable = 4'b1111;
    sensor_in = 4'b0100;
    for (int n = 1; n <= 62; n++) begin
      @(negedge clk);
      if (n == 60) check("d_drst60",  32'(det_rst_n), 32'd1);
      if (n == 60) check("d_dsd60",   32'(det_sensor_data), 32'd0);
      if (n == 61) check("d_drst61",  32'(det_rst_n), 32'd0);
      if (n == 61) check("d_act61",   32'(active_ch), 32'd1);
      if (n == 61) check("d_flags61", 32'(anomaly_flags), 32'd0);
      if (n == 62) check("d_act62",   32'(active_ch), 32'd2);
      if (n == 62) check("d_drst62",  32'(det_rst_n), 32'd1);
      if (n == 62) check("d_dsd62",   32'(det_sensor_data), 32'd1);
      if (n == 62) check("d_flags62", 32'(anomaly_flags), 32'd0);
      det_anomaly = (n == 60);
      if (n == 60) ch_enable = 4'b1101;
    end

    // run dropped at ch3 SAMPLE cnt 10: window completes, then IDLE, then resume.
    do_reset();
    run = 1'b1;
    ch_enable = 4'b1111;
    for (int n = 1; n <= 171; n++) begin
      @(negedge clk);
      if (n == 142) check("r_act142",  32'(active_ch), 32'd3);
      if (n == 163) check("r_drst163", 32'(det_rst_n), 32'd1);
      if (n == 164) check("r_drst164", 32'(det_rst_n), 32'd0);
      if (n == 170) check("r_drst170", 32'(det_rst_n), 32'd0);
      if (n == 170) check("r_act170",  32'(active_ch), 32'd3);
      if (n == 171) check("r_act171",  32'(active_ch), 32'd3);
      if (n == 171) check("r_drst171", 32'(det_rst_n), 32'd1);
      if (n == 142) run = 1'b0;
      if (n == 170) run = 1'b1;
    end

    // Async reset mid-FLUSH with flags 1010.
    do_reset();
    run = 1'b1;
    ch_enable = 4'b1010;
    sensor_in = 4'b1111;
    det_anomaly = 1'b1;
    for (int n = 1; n <= 85; n++) begin
      @(negedge clk);
      if (n == 85) check("a_flags85", 32'(anomaly_flags), 32'ha);
      if (n == 85) check("a_irq85",   32'(irq), 32'd1);
      if (n == 85) check("a_act85",   32'(active_ch), 32'd1);
      if (n == 85) check("a_dsd85",   32'(det_sensor_data), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    det_anomaly = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_tree_scan_scheduler.md
Name: i_tree_scan_scheduler

Overview:
- Time-multiplexes one shared i_tree anomaly detector across NUM_CH 1-bit sensor channels.
- Round-robin dwell on each enabled channel: reset the detector, let it settle, then sample its anomaly output for a window.
- Latches anomaly results into per-channel sticky flags.
- Sits between the TT top-level pins and the i_tree instance; it drives the detector's reset and sensor_data and reads anomaly_detected.

Parameters:
- NUM_CH, 4, number of sensor channels (2..8).
- SETTLE, 8, cycles the detector runs on the new channel before its output is trusted (>=1).
- WINDOW, 32, cycles during which anomaly_detected is sampled (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = scanning enabled; sampled in IDLE and ADVANCE
- ch_enable  in  NUM_CH  per-channel scan mask
- sensor_in  in  NUM_CH  raw sensor bits, one per channel
- flag_clr  in  NUM_CH  write-1-to-clear for anomaly_flags
- det_rst_n  out  1  active-low reset to the shared detector
- det_sensor_data  out  1  sensor bit routed to the detector
- det_anomaly  in  1  detector anomaly_detected output
- active_ch  out  $clog2(NUM_CH)  channel currently owning the detector
- anomaly_flags  out  NUM_CH  sticky per-channel anomaly flags
- scan_done  out  1  1-cycle pulse when the round-robin wraps
- irq  out  1  registered OR of anomaly_flags

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, active_ch=0, det_rst_n=0, det_sensor_data=0, anomaly_flags=0, scan_done=0, irq=0, counter=0.
- States: IDLE, FLUSH, SAMPLE, ADVANCE. All outputs are registered.
- IDLE:
  - det_rst_n=0, det_sensor_data=0.
  - If run=1 and ch_enable!=0: active_ch <= first enabled channel searching upward from active_ch, inclusive, with wrap; go to FLUSH with counter=0.
- FLUSH:
  - det_rst_n=1; det_sensor_data <= sensor_in[active_ch], one-cycle register latency.
  - Lasts exactly SETTLE cycles, then SAMPLE with counter=0. det_anomaly is ignored.
- SAMPLE:
  - Same routing as FLUSH; lasts exactly WINDOW cycles.
  - Each cycle with det_anomaly=1 sets anomaly_flags[active_ch] at the next edge.
- ADVANCE (1 cycle):
  - det_rst_n=0, det_sensor_data=0.
  - next = first enabled channel strictly after active_ch, with wrap. scan_done pulses when next <= active_ch.
  - run=0 or ch_enable==0: go to IDLE and keep active_ch.
  - Otherwise: active_ch <= next, go to FLUSH.
- Per-channel period: SETTLE+WINDOW+1 cycles.
- With only one channel enabled: it is rescanned every period and scan_done pulses every period.
- Enable dropped mid-dwell: if ch_enable[active_ch] becomes 0 in FLUSH or SAMPLE, go to ADVANCE next cycle. No flag is set in the cycle the enable is seen low.
- run=0 mid-dwell: the current dwell completes; the FSM then exits via ADVANCE to IDLE.
- Flags:
  - flag_clr[i]=1 clears anomaly_flags[i].
  - A set and a clear of the same bit in the same cycle: set wins.
- irq <= |anomaly_flags, lagging the flags by one cycle.
- Counter width: $clog2(max(SETTLE,WINDOW)); it must not overflow at either terminal count.
- Reset asserted mid-operation returns everything to reset values immediately. Flags are lost.

Decomposition:
- i_tree_pkg holds:
  - state enum sched_state_t {IDLE, FLUSH, SAMPLE, ADVANCE};
  - default constants I_TREE_SETTLE=8, I_TREE_WINDOW=32, I_TREE_NUM_CH=4.
- One combinational sub-module, i_tree_rr_pick:
  - inputs: mask, start index, inclusive flag;
  - outputs: next index, wrapped, none_valid.
  - Used by both IDLE and ADVANCE.

Test Plan:
- Reset, then run=1, ch_enable=4'b1111, det_anomaly=0:
  - active_ch cycles 0,1,2,3,0 with 41-cycle spacing.
  - det_rst_n low exactly 1 cycle between dwells.
  - scan_done pulses once per 164 cycles; flags stay 0.
- ch_enable=4'b0101, det_anomaly pulsed 1 cycle during SETTLE of ch2 and again at SAMPLE cycle 5 of ch0:
  - only anomaly_flags=4'b0001; irq=1 one cycle later.
- Flag set for ch1 on the same edge as flag_clr=4'b0010:
  - anomaly_flags[1] stays 1.
  - A clear in the following cycle gives 0; irq falls one cycle after that.
- During SAMPLE of ch1, drop ch_enable[1]:
  - ADVANCE occurs next cycle; active_ch moves to 2.
  - det_anomaly=1 asserted in that cycle does not set flags[1].
- run=0 at SAMPLE cycle 10 of ch3:
  - the window completes (22 more cycles), then ADVANCE, then IDLE with det_rst_n=0.
  - run=1 again resumes at ch3.
- rst_n pulsed low mid-FLUSH with flags=4'b1010:
  - all outputs return to reset values asynchronously, before the next clock edge.
